// File: rtl/pipeline_hazard_controller.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes and the
// multiply/divide start/wait handshake. Define STALL_PERF_EN to build the stall counter.
module pipeline_hazard_controller #(
  parameter int MD_TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  id_op1,
  input  logic [3:0]  id_op2,
  input  logic        id_uses_op1,
  input  logic        id_uses_op2,
  input  logic        id_is_muldiv,
  input  logic        ex_mem_read,
  input  logic [3:0]  ex_dest,
  input  logic        branch_taken,
  input  logic        md_done,
  output logic        md_start,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        md_error,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN,
    MD_BUSY,
    MD_RELEASE
  } state_t;

  localparam logic [5:0] CNT_LAST = 6'(MD_TIMEOUT - 1);

  state_t     state;
  state_t     state_next;
  logic [5:0] md_count;
  logic       lu_hazard;
  logic       md_timeout_hit;

  // Register 0 is hardwired, so a load targeting it can never feed a consumer.
  assign lu_hazard = ex_mem_read && (ex_dest != 4'd0) &&
                     ((id_uses_op1 && (id_op1 == ex_dest)) ||
                      (id_uses_op2 && (id_op2 == ex_dest)));

  assign md_timeout_hit = (state == MD_BUSY) && !md_done && (md_count == CNT_LAST);

  // NOTE: every output gets a default at the top of the block so no path leaves
  // a signal unassigned; a missing default here would infer a latch.
  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    md_start    = 1'b0;
    state_next  = state;

    if (rst) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      state_next  = RUN;
    end else begin
      unique case (state)
        RUN: begin
          if (branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (lu_hazard) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
          end else if (id_is_muldiv) begin
            md_start    = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            state_next  = MD_BUSY;
          end
        end
        MD_BUSY: begin
          // EX only holds bubbles here, so a branch resolution cannot occur.
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
          if (md_done || md_timeout_hit) begin
            state_next = MD_RELEASE;
          end
        end
        MD_RELEASE: begin
          // The held mul/div advances without being re-decoded, so no restart.
          state_next = RUN;
        end
        default: begin
          state_next = RUN;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      md_count <= 6'd0;
      md_error <= 1'b0;
    end else begin
      state <= state_next;
      if (md_start) begin
        md_count <= 6'd0;
      end else if (state == MD_BUSY) begin
        md_count <= md_count + 6'd1;
      end
      if (md_timeout_hit) begin
        md_error <= 1'b1;
      end
    end
  end

`ifdef STALL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= 16'd0;
    end else if (!pc_write && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`else
  assign stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed self-checking bench for pipeline_hazard_controller (MD_TIMEOUT = 8).
module tb_pipeline_hazard_controller;

  logic        clk;
  logic        rst;
  logic [3:0]  id_op1;
  logic [3:0]  id_op2;
  logic        id_uses_op1;
  logic        id_uses_op2;
  logic        id_is_muldiv;
  logic        ex_mem_read;
  logic [3:0]  ex_dest;
  logic        branch_taken;
  logic        md_done;
  logic        md_start;
  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        md_error;
  logic [15:0] stall_cycles;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] stall_model = 16'd0;

  // Output vector order: {pc_write, if_id_write, if_id_flush, id_ex_flush, md_start}
  localparam logic [4:0] O_RUN   = 5'b11000;
  localparam logic [4:0] O_LU    = 5'b00010;
  localparam logic [4:0] O_BR    = 5'b11110;
  localparam logic [4:0] O_START = 5'b00011;
  localparam logic [4:0] O_BUSY  = 5'b00010;
  localparam logic [4:0] O_REL   = 5'b11000;
  localparam logic [4:0] O_RST   = 5'b00110;

  pipeline_hazard_controller #(.MD_TIMEOUT(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_op1       (id_op1),
    .id_op2       (id_op2),
    .id_uses_op1  (id_uses_op1),
    .id_uses_op2  (id_uses_op2),
    .id_is_muldiv (id_is_muldiv),
    .ex_mem_read  (ex_mem_read),
    .ex_dest      (ex_dest),
    .branch_taken (branch_taken),
    .md_done      (md_done),
    .md_start     (md_start),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .md_error     (md_error),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Checks the decoded outputs mid-cycle, advances the stall model, then steps past the edge.
  task automatic cycle(input string tag, input logic [4:0] expected);
    @(negedge clk);
    check(tag, {11'd0, pc_write, if_id_write, if_id_flush, id_ex_flush, md_start}, {11'd0, expected});
    if (rst) stall_model = 16'd0;
    else if (!expected[4] && stall_model != 16'hFFFF) stall_model = stall_model + 16'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_stall(input string tag);
`ifdef STALL_PERF_EN
    check(tag, stall_cycles, stall_model);
`else
    check(tag, stall_cycles, 16'd0);
`endif
  endtask

  task automatic clear_inputs();
    id_op1 = 4'd0; id_op2 = 4'd0; id_uses_op1 = 1'b0; id_uses_op2 = 1'b0;
    id_is_muldiv = 1'b0; ex_mem_read = 1'b0; ex_dest = 4'd0;
    branch_taken = 1'b0; md_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();

    // Reset behaviour
    cycle("rst_outs_0", O_RST);
    cycle("rst_outs_1", O_RST);
    check("rst_md_error", {15'd0, md_error}, 16'd0);
    check_stall("rst_stall");
    rst = 1'b0;
    cycle("first_run", O_RUN);

    // Load-use on op2 costs one bubble
    ex_mem_read = 1'b1; ex_dest = 4'd5; id_op2 = 4'd5; id_uses_op2 = 1'b1;
    cycle("lu_op2_stall", O_LU);
    ex_mem_read = 1'b0;
    cycle("lu_op2_resume", O_RUN);

    // Register 0 never hazards
    ex_mem_read = 1'b1; ex_dest = 4'd0; id_op2 = 4'd0;
    cycle("lu_r0_nostall", O_RUN);

    // Matching op1 only hazards when it is actually read
    clear_inputs();
    ex_mem_read = 1'b1; ex_dest = 4'd7; id_op1 = 4'd7;
    cycle("lu_op1_unused", O_RUN);
    id_uses_op1 = 1'b1;
    cycle("lu_op1_stall", O_LU);
    ex_dest = 4'd8;
    cycle("lu_op1_differ", O_RUN);

    // Branch has priority over load-use and over mul/div start
    clear_inputs();
    ex_mem_read = 1'b1; ex_dest = 4'd5; id_op2 = 4'd5; id_uses_op2 = 1'b1;
    branch_taken = 1'b1;
    cycle("br_over_lu", O_BR);
    clear_inputs();
    branch_taken = 1'b1; id_is_muldiv = 1'b1;
    cycle("br_over_md", O_BR);
    branch_taken = 1'b0; id_is_muldiv = 1'b0;
    cycle("br_then_run", O_RUN);
    check_stall("stall_after_lu");

    // Multiply/divide with md_done 4 cycles after md_start
    id_is_muldiv = 1'b1;
    cycle("md_start", O_START);
    cycle("md_busy1", O_BUSY);
    branch_taken = 1'b1;
    cycle("md_busy2_br_ignored", O_BUSY);
    branch_taken = 1'b0;
    cycle("md_busy3", O_BUSY);
    md_done = 1'b1;
    cycle("md_done_cycle", O_BUSY);
    md_done = 1'b0;
    cycle("md_release", O_REL);
    id_is_muldiv = 1'b0;
    cycle("md_back_run", O_RUN);
    check_stall("stall_after_md");

    // md_done while in RUN is ignored
    md_done = 1'b1;
    cycle("done_in_run", O_RUN);
    md_done = 1'b0;
    cycle("done_in_run_after", O_RUN);

    // Back-to-back mul/div, each completing one cycle after start
    id_is_muldiv = 1'b1;
    cycle("b2b_start_a", O_START);
    md_done = 1'b1;
    cycle("b2b_done_a", O_BUSY);
    md_done = 1'b1;
    cycle("b2b_release_a", O_REL);
    md_done = 1'b0;
    cycle("b2b_start_b", O_START);
    md_done = 1'b1;
    cycle("b2b_done_b", O_BUSY);
    md_done = 1'b0;
    cycle("b2b_release_b", O_REL);
    id_is_muldiv = 1'b0;
    cycle("b2b_run", O_RUN);
    check("b2b_no_error", {15'd0, md_error}, 16'd0);

    // Timeout after 8 MD_BUSY cycles
    id_is_muldiv = 1'b1;
    cycle("to_start", O_START);
    for (int i = 1; i <= 7; i++) cycle($sformatf("to_busy%0d", i), O_BUSY);
    check("to_error_before", {15'd0, md_error}, 16'd0);
    cycle("to_busy8", O_BUSY);
    check("to_error_set", {15'd0, md_error}, 16'd1);
    cycle("to_release", O_REL);
    id_is_muldiv = 1'b0;
    md_done = 1'b1;
    cycle("to_run_late_done", O_RUN);
    md_done = 1'b0;
    cycle("to_run", O_RUN);
    check("to_error_sticky", {15'd0, md_error}, 16'd1);
    check_stall("stall_after_timeout");

    // Reset on the third MD_BUSY cycle
    id_is_muldiv = 1'b1;
    cycle("rw_start", O_START);
    cycle("rw_busy1", O_BUSY);
    cycle("rw_busy2", O_BUSY);
    rst = 1'b1;
    cycle("rw_reset", O_RST);
    check("rw_error_cleared", {15'd0, md_error}, 16'd0);
    check_stall("rw_stall_cleared");
    rst = 1'b0; id_is_muldiv = 1'b0; md_done = 1'b1;
    cycle("rw_run_done_ignored", O_RUN);
    md_done = 1'b0;
    cycle("rw_run", O_RUN);
    check("rw_error_still_clear", {15'd0, md_error}, 16'd0);
    check_stall("final_stall");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Sequencing controller for the pipeline registers: it decides cycle by cycle whether PC and IF/ID load, and whether IF/ID or ID/EX is flushed to a bubble. It handles three cases the forwarding path cannot cover: load-use hazards, taken-branch flushes, and the start/wait handshake for the multi-cycle multiply/divide unit. It sits beside the forwarding unit, consumes the same 4-bit register specifiers, and drives the write-enable and flush inputs of the IF/ID and ID/EX buffers.

## Interface
- MD_TIMEOUT, 32: maximum cycles waited for md_done before abort; legal range 2..63.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_op1, id_op2  in  4 each  source register specifiers of the instruction held in IF/ID.
- id_uses_op1, id_uses_op2  in  1 each  the IF/ID instruction actually reads that operand.
- id_is_muldiv  in  1  the IF/ID instruction is a multiply/divide.
- ex_mem_read  in  1  the ID/EX instruction is a load.
- ex_dest  in  4  destination register of the ID/EX instruction.
- branch_taken  in  1  the branch in EX resolved taken this cycle.
- md_done  in  1  single-cycle completion pulse from the multiply/divide unit.
- md_start  out  1  single-cycle start pulse to the multiply/divide unit.
- pc_write, if_id_write  out  1 each  load enables for PC and IF/ID.
- if_id_flush, id_ex_flush  out  1 each  force the next register contents to a bubble.
- md_error  out  1  sticky; the multiply/divide unit timed out.
- stall_cycles  out  16  performance counter; see Configuration.

## Operation
- Register 0 never creates a hazard. lu_hazard = ex_mem_read & (ex_dest != 0) & ((id_uses_op1 & id_op1 == ex_dest) | (id_uses_op2 & id_op2 == ex_dest)).
- States: RUN, MD_BUSY, MD_RELEASE. Outputs are decoded from the current state and the current inputs.
- RUN, priority order:
  1. branch_taken: if_id_flush=1, id_ex_flush=1, pc_write=1, if_id_write=1. Stay in RUN.
  2. lu_hazard: pc_write=0, if_id_write=0, id_ex_flush=1. This inserts one bubble. Stay in RUN.
  3. id_is_muldiv: md_start=1, pc_write=0, if_id_write=0, id_ex_flush=1. Clear the timeout counter. Go to MD_BUSY.
  4. Otherwise: pc_write=1, if_id_write=1, flushes=0.
- MD_BUSY:
  - pc_write=0, if_id_write=0, id_ex_flush=1, md_start=0.
  - Counter increments each cycle.
  - md_done=1: go to MD_RELEASE.
  - Counter reaches MD_TIMEOUT-1 without md_done: set md_error, go to MD_RELEASE.
  - branch_taken is ignored; EX holds only bubbles in this state.
- MD_RELEASE (exactly one cycle):
  - pc_write=1, if_id_write=1, flushes=0, md_start=0. The multiply/divide instruction advances into ID/EX.
  - id_is_muldiv is not evaluated this cycle, so the same instruction does not restart the unit.
  - Next state is RUN.
- md_done while in RUN or MD_RELEASE is ignored.
- md_error clears only on rst.

## Timing
- While rst=1: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1, md_start=0. State becomes RUN; the counter, md_error and stall_cycles are cleared.
- The first cycle after rst falls is RUN with normal decoding.
- Load-use costs exactly 1 stall cycle.
- A multiply/divide with md_done arriving N cycles after md_start (N ≥ 1) costs N+1 cycles with pc_write=0: the md_start cycle plus N-1 MD_BUSY cycles, then the done cycle. MD_RELEASE follows.
- Timeout: md_error rises on the edge after the MD_TIMEOUT-th MD_BUSY cycle.
- md_start is high for exactly one cycle per instruction, never two cycles in a row.
- Reset asserted mid-MD_BUSY: returns to RUN. No md_start is reissued until a new RUN decode.
- A back-to-back multiply/divide in IF/ID after MD_RELEASE starts in the following RUN cycle.

## Configuration
- STALL_PERF_EN defined: stall_cycles increments on every non-reset cycle where pc_write=0 and saturates at 16'hFFFF.
- STALL_PERF_EN undefined: the counter logic is omitted and stall_cycles is tied to 0.

## Test plan
- Load-use: ex_mem_read=1, ex_dest=5, id_op2=5, id_uses_op2=1 → one cycle with pc_write=0, if_id_write=0, id_ex_flush=1. Same stimulus with ex_dest=0 → no stall.
- Branch beats hazard: branch_taken=1 together with the load-use stimulus above → if_id_flush=1, id_ex_flush=1, pc_write=1.
- Multiply/divide: id_is_muldiv=1, md_done pulsed 4 cycles after md_start → md_start high 1 cycle, pc_write=0 for 5 cycles, then MD_RELEASE with pc_write=1, then RUN. With STALL_PERF_EN, stall_cycles=5.
- Timeout: MD_TIMEOUT=8, md_done never asserted → md_error=1 after 8 MD_BUSY cycles, MD_RELEASE, then RUN; md_error stays high.
- Reset mid-wait: rst pulsed on the 3rd MD_BUSY cycle → all outputs take reset values, md_error=0; RUN on the next cycle, and a later md_done has no effect.
- Back-to-back: two multiply/divide instructions in sequence → two distinct md_start pulses separated by the MD_RELEASE cycle.
